// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch front end
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Default PC width; fetch_unit re-declares the entry with its own PC_W
    localparam int PC_W_DEF = 9;

    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - shift-register FIFO whose head entry always sits in register slot 0
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem [DEPTH];
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] wr_idx;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // New entry lands just behind the last valid one, after any shift
    assign wr_idx  = AW'(do_pop ? count - 1'b1 : count);
    assign head    = mem[0];

    // Occupancy: reset and flush empty the buffer; push and pop may coincide
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + 1'b1;
        end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
        end
    end

    // Storage: shift toward slot 0 on pop, then write the pushed entry
    always_ff @(posedge clk) begin
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V fetch front end (PC, imem issue, {pc,instr} buffer); FETCH_PERF_EN adds perf counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = 9,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               imem_req,
    output logic [PC_W-3:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] issued_pc;
    logic            inflight;
    logic            squash;
    logic            room;
    logic            issue;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   count;
    entry_t          push_entry;
    entry_t          head;

    // A redirect kills whatever response returns this cycle
    assign squash = redirect_valid;
    assign pop    = if_valid && if_ready;

    // Capacity is counted after this cycle's pop so a steady stream sustains one
    // fetch per cycle while never issuing more than the buffer can absorb
    assign room = pop ? (int'(count) + int'(inflight) <= FIFO_DEPTH)
                      : (!fifo_full && (int'(count) + int'(inflight) < FIFO_DEPTH));

    assign issue      = !reset && (state == S_RUN) && !halt && !redirect_valid && room;
    assign push       = inflight && !squash;
    assign push_entry = '{pc: issued_pc, instr: imem_rdata};

    assign imem_req  = issue;
    assign imem_addr = pc[PC_W-1:2];
    assign if_valid  = !reset && !fifo_empty;
    assign if_pc     = reset ? '0 : head.pc;
    assign if_instr  = reset ? '0 : head.instr;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM: one idle cycle after reset, then run until the next reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            case (state)
                S_BOOT:  state <= S_RUN;
                default: state <= S_RUN;
            endcase
        end
    end

    // Program counter: redirect beats sequential advance; low bits forced to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~PC_W'(3);
        end else if (issue) begin
            pc <= pc + PC_W'(4);
        end
    end

    // Track the single outstanding imem read and the PC it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight  <= 1'b0;
            issued_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued_pc <= pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Completed transfers and backpressure cycles; both wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (if_valid && !if_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a transaction-level fetch model
module tb_fetch_unit;

    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halt;
    logic            imem_req;
    logic [PC_W-3:0] imem_addr;
    logic [31:0]     imem_rdata = '0;
    logic            if_valid;
    logic            if_ready;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_stall;
`endif

    int checks   = 0;
    int failures = 0;
    int n_xfer   = 0;

    fetch_unit u_dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Instruction memory contents: byte address of the word plus a tag bit
    function automatic logic [31:0] instr_of(input logic [PC_W-3:0] a);
        return 32'h4000_0000 | {23'd0, a, 2'b00};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous instruction memory: data one cycle after the request, junk otherwise
    always @(posedge clk) begin
        imem_rdata <= imem_req ? instr_of(imem_addr) : $urandom();
    end

    // Reference model: requests and deliveries each walk a sequential PC stream
    // that restarts at the redirect target or at the reset PC
    logic [PC_W-1:0] exp_req_pc = '0;
    logic [PC_W-1:0] exp_del_pc = '0;
    logic [PC_W-1:0] prev_pc    = '0;
    logic [31:0]     prev_instr = '0;
    logic            prev_hold  = 1'b0;
    logic            prev_redir = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            check_eq("rst_req", 32'(imem_req), 32'd0);
            check_eq("rst_valid", 32'(if_valid), 32'd0);
            check_eq("rst_pc", 32'(if_pc), 32'd0);
            check_eq("rst_instr", if_instr, 32'd0);
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", 32'(if_valid), 32'd1);
                check_eq("hold_pc", 32'(if_pc), 32'(prev_pc));
                check_eq("hold_instr", if_instr, prev_instr);
            end
            if (prev_redir) begin
                check_eq("redir_valid", 32'(if_valid), 32'd0);
            end
            if (imem_req) begin
                check_eq("req_gate", 32'(halt || redirect_valid), 32'd0);
                check_eq("req_addr", 32'(imem_addr), 32'(exp_req_pc[PC_W-1:2]));
                exp_req_pc = exp_req_pc + 9'd4;
            end
            if (if_valid && if_ready) begin
                check_eq("del_pc", 32'(if_pc), 32'(exp_del_pc));
                check_eq("del_instr", if_instr, instr_of(exp_del_pc[PC_W-1:2]));
                exp_del_pc = exp_del_pc + 9'd4;
                n_xfer++;
            end
        end
        prev_hold  = !reset && if_valid && !if_ready && !redirect_valid;
        prev_redir = !reset && redirect_valid;
        prev_pc    = if_pc;
        prev_instr = if_instr;
        if (reset) begin
            exp_req_pc = '0;
            exp_del_pc = '0;
        end else if (redirect_valid) begin
            exp_req_pc = redirect_pc & 9'h1FC;
            exp_del_pc = redirect_pc & 9'h1FC;
        end
    end

    initial begin
        int x0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        if_ready       = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b0;

        // Boot latency and one-per-cycle streaming
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("t1_req", 32'(imem_req), 32'(k >= 1));
            if (k >= 1) check_eq("t1_addr", 32'(imem_addr), 32'(k - 1));
            check_eq("t1_valid", 32'(if_valid), 32'(k >= 3));
            if (k >= 3) begin
                check_eq("t1_pc", 32'(if_pc), 32'(4 * (k - 3)));
                check_eq("t1_instr", if_instr, instr_of(7'(k - 3)));
            end
            tick();
        end

        // Backpressure: buffer fills, issue stops, head holds, then resumes gap-free
        if_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t2_req", 32'(imem_req), 32'd0);
            check_eq("t2_valid", 32'(if_valid), 32'd1);
            check_eq("t2_pc", 32'(if_pc), 32'd28);
            tick();
        end
        if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("t2_resume_valid", 32'(if_valid), 32'd1);
            check_eq("t2_resume_pc", 32'(if_pc), 32'(28 + 4 * k));
            tick();
        end

        // Redirect to a misaligned target with a full buffer
        if_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 9'h043;
        @(negedge clk);
        check_eq("t3_req_t", 32'(imem_req), 32'd0);
        tick();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        @(negedge clk);
        check_eq("t3_valid_t1", 32'(if_valid), 32'd0);
        check_eq("t3_req_t1", 32'(imem_req), 32'd1);
        check_eq("t3_addr_t1", 32'(imem_addr), 32'h10);
        tick();
        @(negedge clk);
        check_eq("t3_valid_t2", 32'(if_valid), 32'd0);
        tick();
        @(negedge clk);
        check_eq("t3_valid_t3", 32'(if_valid), 32'd1);
        check_eq("t3_pc_t3", 32'(if_pc), 32'h40);
        tick();
        tick();

        // Halt: issue stops at once, buffered and in-flight entries drain
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("t4_req", 32'(imem_req), 32'd0);
            check_eq("t4_valid", 32'(if_valid), 32'(k < 2));
            if (k < 2) check_eq("t4_pc", 32'(if_pc), 32'(32'h48 + 4 * k));
            tick();
        end
        halt = 1'b0;
        @(negedge clk);
        check_eq("t4_resume_req", 32'(imem_req), 32'd1);
        check_eq("t4_resume_addr", 32'(imem_addr), 32'h14);
        tick();
        tick();
        @(negedge clk);
        check_eq("t4_resume_pc", 32'(if_pc), 32'h50);
        tick();

        // Reset with a buffered entry and a request in flight
        reset    = 1'b1;
        if_ready = 1'b0;
        tick();
        reset    = 1'b0;
        if_ready = 1'b1;
        @(negedge clk);
        check_eq("t5_valid", 32'(if_valid), 32'd0);
        check_eq("t5_req", 32'(imem_req), 32'd0);
        check_eq("t5_addr", 32'(imem_addr), 32'd0);
        tick();
        tick();
        tick();
        @(negedge clk);
        check_eq("t5_first_valid", 32'(if_valid), 32'd1);
        check_eq("t5_first_pc", 32'(if_pc), 32'd0);
        check_eq("t5_first_instr", if_instr, instr_of(7'd0));
        tick();

        // Randomized traffic checked by the reference model
        x0 = n_xfer;
        for (int c = 0; c < 3000; c++) begin
            if_ready       = ($urandom_range(0, 99) < 75);
            halt           = ($urandom_range(0, 99) < 10);
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc    = 9'($urandom());
            reset          = ($urandom_range(0, 999) < 5);
            tick();
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        check_eq("rand_progress", 32'((n_xfer - x0) > 900), 32'd1);

`ifdef FETCH_PERF_EN
        // 10 transfers and 3 stall cycles after a fresh reset
        reset    = 1'b1;
        if_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            if_ready = !(k >= 8 && k <= 10);
            if (k == 16) begin
                @(negedge clk);
                check_eq("perf_fetched", perf_fetched, 32'd10);
                check_eq("perf_stall", perf_stall, 32'd3);
            end
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
